// File: rtl/simple_cpu_if.sv
// Instruction fetch bus between the core and an external instruction memory.
// The core presents PC_OUT; the memory answers with INSTRUCTION in the same cycle.
interface simple_cpu_if;
    logic [31:0] PC_OUT;
    logic [31:0] INSTRUCTION;

    modport master (output PC_OUT, input INSTRUCTION);
    modport slave  (input PC_OUT, output INSTRUCTION);
endinterface

// File: rtl/simple_cpu.sv
// Single-cycle 8-bit core: 8x8 register file, ALU, decoder and PC/branch logic.
// Every instruction reads, executes and commits its write and PC update on one rising edge.
module simple_cpu_regfile (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       we,
    input  logic [2:0] wa,
    input  logic [7:0] wd,
    input  logic [2:0] ra1,
    input  logic [2:0] ra2,
    output logic [7:0] rd1,
    output logic [7:0] rd2
);
    logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r0 <= 8'h00; r1 <= 8'h00; r2 <= 8'h00; r3 <= 8'h00;
            r4 <= 8'h00; r5 <= 8'h00; r6 <= 8'h00; r7 <= 8'h00;
        end else if (we) begin
            case (wa)
                3'd0: r0 <= wd;
                3'd1: r1 <= wd;
                3'd2: r2 <= wd;
                3'd3: r3 <= wd;
                3'd4: r4 <= wd;
                3'd5: r5 <= wd;
                3'd6: r6 <= wd;
                default: r7 <= wd;
            endcase
        end
    end

    // Reads are combinational and see the pre-edge contents, so a source equal to RD uses the old value.
    always_comb begin
        case (ra1)
            3'd0: rd1 = r0;
            3'd1: rd1 = r1;
            3'd2: rd1 = r2;
            3'd3: rd1 = r3;
            3'd4: rd1 = r4;
            3'd5: rd1 = r5;
            3'd6: rd1 = r6;
            default: rd1 = r7;
        endcase
        case (ra2)
            3'd0: rd2 = r0;
            3'd1: rd2 = r1;
            3'd2: rd2 = r2;
            3'd3: rd2 = r3;
            3'd4: rd2 = r4;
            3'd5: rd2 = r5;
            3'd6: rd2 = r6;
            default: rd2 = r7;
        endcase
    end
endmodule

module simple_cpu #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic         CLK,
    input  logic         RESET,
    simple_cpu_if.master bus
);
    typedef enum logic [2:0] {
        ALU_PASS,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR
    } alu_op_t;

    logic [31:0] pc;
    logic [7:0]  opcode;
    logic [2:0]  rd_addr;
    logic [2:0]  rs1_addr;
    logic [2:0]  rs2_addr;
    logic [7:0]  imm;
    logic [7:0]  branch_off;
    logic [4:0]  unused_rs1_hi;

    logic        reg_we;
    logic        use_imm;
    logic        is_jump;
    logic        is_beq;
    alu_op_t     alu_op;

    logic [7:0]  rs1_data;
    logic [7:0]  rs2_data;
    logic [7:0]  operand2;
    logic [7:0]  alu_result;
    logic        zero;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic        take_branch;

    assign opcode        = bus.INSTRUCTION[31:24];
    assign branch_off    = bus.INSTRUCTION[23:16];
    assign rd_addr       = bus.INSTRUCTION[18:16];
    assign rs1_addr      = bus.INSTRUCTION[10:8];
    assign rs2_addr      = bus.INSTRUCTION[2:0];
    assign imm           = bus.INSTRUCTION[7:0];
    assign unused_rs1_hi = bus.INSTRUCTION[15:11];

    simple_cpu_regfile u_regfile (
        .CLK   (CLK),
        .RESET (RESET),
        .we    (reg_we),
        .wa    (rd_addr),
        .wd    (alu_result),
        .ra1   (rs1_addr),
        .ra2   (rs2_addr),
        .rd1   (rs1_data),
        .rd2   (rs2_data)
    );

    // Unlisted opcodes fall through the defaults and behave as NOPs.
    always_comb begin
        reg_we  = 1'b0;
        use_imm = 1'b0;
        is_jump = 1'b0;
        is_beq  = 1'b0;
        alu_op  = ALU_PASS;
        case (opcode)
            8'h00: begin reg_we = 1'b1; use_imm = 1'b1; alu_op = ALU_PASS; end
            8'h01: begin reg_we = 1'b1; alu_op = ALU_PASS; end
            8'h02: begin reg_we = 1'b1; alu_op = ALU_ADD; end
            8'h03: begin reg_we = 1'b1; alu_op = ALU_SUB; end
            8'h04: begin reg_we = 1'b1; alu_op = ALU_AND; end
            8'h05: begin reg_we = 1'b1; alu_op = ALU_OR; end
            8'h06: is_jump = 1'b1;
            8'h07: begin is_beq = 1'b1; alu_op = ALU_SUB; end
            default: ;
        endcase
    end

    assign operand2 = use_imm ? imm : rs2_data;

    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            ALU_PASS: alu_result = operand2;
            ALU_ADD:  alu_result = rs1_data + operand2;
            ALU_SUB:  alu_result = rs1_data + (~operand2 + 8'd1);
            ALU_AND:  alu_result = rs1_data & operand2;
            ALU_OR:   alu_result = rs1_data | operand2;
            default:  alu_result = 8'h00;
        endcase
    end

    assign zero = (alu_result == 8'h00);

    // The offset counts words relative to the following instruction.
    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + {{22{branch_off[7]}}, branch_off, 2'b00};
    assign take_branch   = is_jump | (is_beq & zero);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc <= RESET_PC;
        end else begin
            pc <= take_branch ? branch_target : pc_plus4;
        end
    end

    assign bus.PC_OUT = pc;
endmodule

// File: tb/tb_simple_cpu.sv
// Self-checking bench for simple_cpu: directed program fragments plus random instructions,
// each compared against an instruction-level reference model of PC and registers.
module tb_simple_cpu;
    logic CLK;
    logic RESET;
    int   n_compared;
    int   n_mismatched;

    logic [31:0] m_pc;
    logic [7:0]  m_reg [8];

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_NOP   = 8'h2A;

    simple_cpu_if bus ();

    simple_cpu #(.RESET_PC(32'd0)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] rd,
                                       input logic [7:0] rs1, input logic [7:0] rs2imm);
        return {op, rd, rs1, rs2imm};
    endfunction

    function automatic logic [7:0] getReg(input int i);
        case (i)
            0: return dut.u_regfile.r0;
            1: return dut.u_regfile.r1;
            2: return dut.u_regfile.r2;
            3: return dut.u_regfile.r3;
            4: return dut.u_regfile.r4;
            5: return dut.u_regfile.r5;
            6: return dut.u_regfile.r6;
            default: return dut.u_regfile.r7;
        endcase
    endfunction

    // Architectural model: one instruction's effect expressed directly from the ISA rules.
    task automatic modelExec(input logic [31:0] instr);
        logic [7:0] op, a, b, imm;
        int rd, off;
        logic write;
        logic [7:0] result;
        op  = instr[31:24];
        rd  = int'(instr[18:16]);
        a   = m_reg[instr[10:8]];
        b   = m_reg[instr[2:0]];
        imm = instr[7:0];
        off = int'($signed(instr[23:16]));
        write  = 1'b1;
        result = 8'h00;
        m_pc   = m_pc + 32'd4;
        case (op)
            OP_LOADI: result = imm;
            OP_MOV:   result = b;
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_J:     begin write = 1'b0; m_pc = m_pc + 32'(off * 4); end
            OP_BEQ:   begin write = 1'b0; if (a == b) m_pc = m_pc + 32'(off * 4); end
            default:  write = 1'b0;
        endcase
        if (write) m_reg[rd] = result;
    endtask

    task automatic modelReset();
        m_pc = 32'd0;
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".pc"}, bus.PC_OUT, m_pc);
        for (int i = 0; i < 8; i++)
            checkValue($sformatf("%s.r%0d", tag, i), {24'd0, getReg(i)}, {24'd0, m_reg[i]});
    endtask

    // Called just after a falling edge; leaves the bench just after the next falling edge.
    task automatic applyStimulus(input string tag, input logic [31:0] instr);
        bus.INSTRUCTION = instr;
        modelExec(instr);
        @(posedge CLK);
        #1;
        checkOutput(tag);
        @(negedge CLK);
    endtask

    // Asserts reset between edges and checks the clear happens before any clock edge.
    task automatic applyReset(input string tag);
        #2;
        RESET = 1'b0;
        #1;
        modelReset();
        checkOutput(tag);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        RESET = 1'b0;
        bus.INSTRUCTION = mk(OP_NOP, 8'd0, 8'd0, 8'd0);
        modelReset();

        // Reset held across two edges.
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_hold");
        RESET = 1'b1;

        applyStimulus("fetch0", mk(OP_NOP, 8'd0, 8'd0, 8'd0));
        applyStimulus("fetch1", mk(OP_NOP, 8'd0, 8'd0, 8'd0));
        applyStimulus("fetch2", mk(OP_NOP, 8'd0, 8'd0, 8'd0));
        checkValue("fetch_pc12", bus.PC_OUT, 32'd12);

        applyStimulus("loadi_r1", mk(OP_LOADI, 8'd1, 8'd0, 8'h05));
        applyStimulus("loadi_r2", mk(OP_LOADI, 8'd2, 8'd0, 8'h03));
        applyStimulus("add",      mk(OP_ADD, 8'd3, 8'd1, 8'd2));
        applyStimulus("sub",      mk(OP_SUB, 8'd4, 8'd1, 8'd2));
        applyStimulus("and",      mk(OP_AND, 8'd5, 8'd1, 8'd2));
        applyStimulus("or",       mk(OP_OR,  8'd6, 8'd1, 8'd2));
        applyStimulus("mov",      mk(OP_MOV, 8'd7, 8'd0, 8'd1));
        checkValue("alu_r3", {24'd0, getReg(3)}, 32'h08);
        checkValue("alu_r4", {24'd0, getReg(4)}, 32'h02);
        checkValue("alu_r5", {24'd0, getReg(5)}, 32'h01);
        checkValue("alu_r6", {24'd0, getReg(6)}, 32'h07);
        checkValue("alu_r7", {24'd0, getReg(7)}, 32'h05);

        applyStimulus("wrap_r1", mk(OP_LOADI, 8'd1, 8'd0, 8'hFF));
        applyStimulus("wrap_r2", mk(OP_LOADI, 8'd2, 8'd0, 8'h01));
        applyStimulus("wrap_add", mk(OP_ADD, 8'd3, 8'd1, 8'd2));
        applyStimulus("wrap_sub", mk(OP_SUB, 8'd4, 8'd2, 8'd1));
        checkValue("wrap_r3", {24'd0, getReg(3)}, 32'h00);
        checkValue("wrap_r4", {24'd0, getReg(4)}, 32'h02);
        applyStimulus("self_add", mk(OP_ADD, 8'd1, 8'd1, 8'd1));
        applyStimulus("unknown_op", mk(OP_NOP, 8'd5, 8'd1, 8'd2));

        // Jumps from known PCs.
        applyReset("reset_jump");
        applyStimulus("j_pre0", mk(OP_LOADI, 8'd6, 8'd0, 8'h5A));
        applyStimulus("j_pre1", mk(OP_NOP, 8'd0, 8'd0, 8'd0));
        applyStimulus("j_fwd",  mk(OP_J, 8'h02, 8'd0, 8'd0));
        checkValue("j_fwd_pc", bus.PC_OUT, 32'd20);
        applyStimulus("j_back", mk(OP_J, 8'hFE, 8'd0, 8'd0));
        checkValue("j_back_pc", bus.PC_OUT, 32'd16);
        checkValue("j_r6_kept", {24'd0, getReg(6)}, 32'h5A);

        // Taken and not-taken branches, each at PC=12.
        applyReset("reset_beq_t");
        applyStimulus("beq_t0", mk(OP_LOADI, 8'd1, 8'd0, 8'h05));
        applyStimulus("beq_t1", mk(OP_LOADI, 8'd2, 8'd0, 8'h05));
        applyStimulus("beq_t2", mk(OP_NOP, 8'd0, 8'd0, 8'd0));
        applyStimulus("beq_taken", mk(OP_BEQ, 8'h01, 8'd1, 8'd2));
        checkValue("beq_taken_pc", bus.PC_OUT, 32'd20);
        applyReset("reset_beq_n");
        applyStimulus("beq_n0", mk(OP_LOADI, 8'd1, 8'd0, 8'h05));
        applyStimulus("beq_n1", mk(OP_LOADI, 8'd2, 8'd0, 8'h03));
        applyStimulus("beq_n2", mk(OP_NOP, 8'd0, 8'd0, 8'd0));
        applyStimulus("beq_not", mk(OP_BEQ, 8'h01, 8'd1, 8'd2));
        checkValue("beq_not_pc", bus.PC_OUT, 32'd16);
        applyStimulus("beq_n4", mk(OP_LOADI, 8'd3, 8'd0, 8'h77));
        applyStimulus("beq_n5", mk(OP_NOP, 8'd0, 8'd0, 8'd0));
        checkValue("midrun_pc24", bus.PC_OUT, 32'd24);

        // Asynchronous clear with a live instruction on the bus at PC=24.
        bus.INSTRUCTION = mk(OP_LOADI, 8'd4, 8'd0, 8'h99);
        applyReset("reset_midrun");
        checkValue("midrun_r3", {24'd0, getReg(3)}, 32'h00);

        // Random instruction stream, opcodes biased toward the defined set.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] instr;
            instr = $urandom;
            instr[31:24] = 8'($urandom_range(0, 9));
            if ($urandom_range(0, 15) == 0) instr[31:24] = 8'($urandom);
            applyStimulus($sformatf("rand%0d", n), instr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/simple_cpu.md
Name: simple_cpu

Overview:
- Single-cycle 8-bit processor core with a 32-bit byte-addressed PC and 32-bit fixed-format instructions.
- Contains an 8x8-bit register file, an ALU, a control decoder and PC/branch logic.
- Instruction memory is external: the core drives PC_OUT, and the environment returns the instruction word on INSTRUCTION within the same cycle. No data memory in this block.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RESET  input  1  asynchronous, active-low reset.
- PC_OUT  output  32  current program counter, a byte address that is always a multiple of 4.
- INSTRUCTION  input  32  instruction word fetched from PC_OUT; valid up to 2 time units after PC_OUT changes.

Behaviour:
- Instruction fields:
  - OP = [31:24]
  - RD = [23:16]; only bits [18:16] are used for register writes.
  - RS1 = [15:8]; only [10:8] are used.
  - RS2/IMM = [7:0]; [2:0] are used when the field names a register.
- Reset: while RESET=0, PC_OUT=RESET_PC and all 8 registers read 0, regardless of CLK. Execution starts on the first rising CLK after RESET returns high.
- Register file:
  - 2 combinational read ports (RS1, RS2) and 1 write port (RD).
  - Write happens at rising CLK when write-enable is set.
  - A same-cycle read of the register being written returns the old value.
- Datapath:
  - OPERAND2 = IMM for loadi; otherwise register[RS2].
  - sub computes register[RS1] + (~OPERAND2 + 1), i.e. 8-bit two's complement.
  - All ALU results are truncated to 8 bits; no flags other than ZERO (result == 0).
- Opcodes (all other opcodes are NOPs: no write, PC+4):
  - 0x00 loadi: RD <- IMM
  - 0x01 mov: RD <- reg[RS2]
  - 0x02 add: RD <- reg[RS1] + reg[RS2]
  - 0x03 sub: RD <- reg[RS1] - reg[RS2]
  - 0x04 and: RD <- reg[RS1] & reg[RS2]
  - 0x05 or: RD <- reg[RS1] | reg[RS2]
  - 0x06 j: unconditional jump, no write
  - 0x07 beq: jump if reg[RS1] == reg[RS2], implemented as sub with ZERO; no write
- Branch target: PC+4 + (sign_extend(INSTRUCTION[23:16]) << 2). Offset range is -128..+127 words.
- PC update at each rising CLK:
  - j, or beq with ZERO=1: PC <- branch target.
  - otherwise: PC <- PC+4.
  - Wrap-around at 2^32 is permitted.
- Latency:
  - Every instruction completes in exactly one cycle.
  - Its register write and PC update commit on the same rising edge.
  - The next instruction sees the written value.
- Write-enable is asserted only for opcodes 0x00-0x05. Writing the same register as a source (e.g. add r1 r1 r1) uses the pre-edge value.
- Reset asserted mid-execution: PC and registers clear immediately; the in-flight instruction is discarded.
- The register file instance is named u_regfile, with storage visible as r0..r7 for bench observation.

Test Plan:
- Reset/fetch: hold RESET=0 across 2 edges -> PC_OUT=0 and r0..r7=0. Release RESET -> PC_OUT steps 0, 4, 8, 12 on successive edges.
- ALU ops: loadi r1 0x05; loadi r2 0x03; then the following -> r3=0x08, r4=0x02, r5=0x01, r6=0x07, r7=0x05:
  - add r3 r1 r2
  - sub r4 r1 r2
  - and r5 r1 r2
  - or r6 r1 r2
  - mov r7 r1
- Wrap/negatives: loadi r1 0xFF; loadi r2 0x01; add r3 r1 r2 -> r3=0x00. Then sub r4 r2 r1 -> r4=0x02.
- Jump: j with offset +2 at PC=8 -> next PC_OUT=20. j with offset 0xFE (-2) at PC=20 -> next PC_OUT=16; no register changes.
- beq: r1=r2=5, beq +1 at PC=12 -> PC=20. With r1=5, r2=3 -> PC=16.
- Async reset mid-run: drive RESET=0 between clock edges at PC=24 -> PC_OUT=0 and registers=0 immediately, before any clock edge. Unknown opcode 0x2A -> PC+4, no write.
